// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared widths, defaults, fetch entry and instruction field helpers
package instr_fetch_unit_pkg;

    localparam int PC_WIDTH       = 8;
    localparam int INSTR_WIDTH    = 32;
    localparam int DEF_FIFO_DEPTH = 2;
    localparam logic [PC_WIDTH-1:0] DEF_RESET_PC = '0;

    // Instruction field positions used by the downstream decode stage.
    localparam int COND_MSB   = 31;
    localparam int COND_LSB   = 28;
    localparam int OPCODE_MSB = 27;
    localparam int OPCODE_LSB = 24;
    localparam int S_BIT      = 23;
    localparam int DEST_MSB   = 22;
    localparam int DEST_LSB   = 19;
    localparam int SRC1_MSB   = 18;
    localparam int SRC1_LSB   = 15;
    localparam int SRC2_MSB   = 14;
    localparam int SRC2_LSB   = 11;
    localparam int IMM_MSB    = 18;
    localparam int IMM_LSB    = 3;
    localparam int SR_MSB     = 2;
    localparam int SR_LSB     = 0;

    typedef logic [PC_WIDTH-1:0]    pc_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    // One prefetch FIFO entry: the returned word tagged with its fetch address.
    typedef struct packed {
        pc_t    pc;
        instr_t word;
    } fetch_entry_t;

    typedef struct packed {
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic        s;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [15:0] imm;
        logic [2:0]  sr;
    } instr_fields_t;

    // Split a raw word into its fields; imm overlaps src1/src2 by encoding.
    function automatic instr_fields_t decode_fields(input instr_t w);
        instr_fields_t f;
        f.cond   = w[COND_MSB:COND_LSB];
        f.opcode = w[OPCODE_MSB:OPCODE_LSB];
        f.s      = w[S_BIT];
        f.dest   = w[DEST_MSB:DEST_LSB];
        f.src1   = w[SRC1_MSB:SRC1_LSB];
        f.src2   = w[SRC2_MSB:SRC2_LSB];
        f.imm    = w[IMM_MSB:IMM_LSB];
        f.sr     = w[SR_MSB:SR_LSB];
        return f;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - Ram fetch port and instruction delivery bus
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic   fetch_req;
    pc_t    fetch_address;
    logic   fetch_valid;
    instr_t fetch_data;
    logic   instr_valid;
    logic   instr_ready;
    instr_t instr;
    pc_t    instr_pc;

    // Fetch unit side.
    modport master (
        output fetch_req,
        output fetch_address,
        input  fetch_valid,
        input  fetch_data,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    // Ram plus consumer side.
    modport slave (
        input  fetch_req,
        input  fetch_address,
        output fetch_valid,
        output fetch_data,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// rtl/instr_fetch_unit_fetch_fifo.sv - small prefetch FIFO with sync clear, count and held output
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] last_q;
    logic             rd_fire;

    assign rd_fire = rd_en && (cnt != '0);
    assign empty   = (cnt == '0);
    assign count   = cnt;

    // When empty the output holds the last popped entry instead of stale storage.
    assign rd_data = empty ? last_q : mem[rd_ptr];

    // Storage array; only written, never reset.
    always_ff @(posedge clk) begin
        if (wr_en && !clear && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and last-popped holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({wr_en, rd_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, credit-limited fetch issue, redirect flush and prefetch buffering
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                  FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = DEF_RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                halt,
    input  logic                redirect_en,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                protocol_err,
    instr_fetch_unit_if.master  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 2;

    pc_t          pc_q;
    pc_t          resp_pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] drop_cnt_q;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] credit_used;
    logic [CW-1:0] resp_used;
    logic          issue;
    logic          resp_drop;
    logic          resp_accept;
    logic          resp_err;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          fifo_empty;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;

    // Every fetch holds a credit from issue until its word leaves the FIFO
    // (or is discarded), so the FIFO can never be asked to overflow.
    assign credit_used = SW'(outstanding_q) + SW'(fifo_count) + SW'(drop_cnt_q);
    assign issue       = !reset && !halt && !redirect_en && (credit_used < SW'(FIFO_DEPTH));

    // Responses are in order: words for flushed fetches always arrive first.
    assign resp_drop   = bus.fetch_valid && (drop_cnt_q != '0);
    assign resp_accept = bus.fetch_valid && (drop_cnt_q == '0) && (outstanding_q != '0);
    assign resp_err    = bus.fetch_valid && (drop_cnt_q == '0) && (outstanding_q == '0);
    assign resp_used   = CW'(resp_drop | resp_accept);

    assign fifo_wr  = resp_accept && !redirect_en;
    assign fifo_rd  = bus.instr_valid && bus.instr_ready && !redirect_en;
    assign wr_entry = '{pc: resp_pc_q, word: bus.fetch_data};

    assign bus.fetch_req     = issue;
    assign bus.fetch_address = pc_q;
    assign bus.instr_valid   = !reset && !fifo_empty;
    assign bus.instr         = head.word;
    assign bus.instr_pc      = head.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (redirect_en),
        .wr_en   (fifo_wr),
        .wr_data (wr_entry),
        .rd_en   (fifo_rd),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    // Fetch PC and the tag applied to the next accepted response.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
        end else if (redirect_en) begin
            pc_q      <= redirect_pc;
            resp_pc_q <= redirect_pc;
        end else begin
            if (issue) begin
                pc_q <= pc_q + 1'b1;
            end
            if (fifo_wr) begin
                resp_pc_q <= resp_pc_q + 1'b1;
            end
        end
    end

    // In-flight accounting; a redirect turns every live fetch into one to discard.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else if (redirect_en) begin
            outstanding_q <= '0;
            drop_cnt_q    <= drop_cnt_q + outstanding_q - resp_used;
        end else begin
            outstanding_q <= outstanding_q + CW'(issue) - CW'(resp_accept);
            drop_cnt_q    <= drop_cnt_q - CW'(resp_drop);
        end
    end

    // Sticky flag for a Ram response nobody asked for.
    always_ff @(posedge clk) begin
        if (reset) begin
            protocol_err <= 1'b0;
        end else if (resp_err) begin
            protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench with Ram model and instruction stream reference
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        redirect_en;
    logic [7:0]  redirect_pc;
    logic        protocol_err;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .FIFO_DEPTH (2),
        .RESET_PC   (8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .halt         (halt),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .protocol_err (protocol_err),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        int         due;
    } ram_req_t;

    ram_req_t   ram_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         lat = 1;
    int         consumed = 0;
    bit         spurious = 0;
    logic [7:0] exp_pc;
    logic [7:0] exp_fetch;
    logic [7:0] held_pc;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, a + 8'h11};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: Ram drives its response, outputs are checked against the
    // stream model, then the edge happens.
    task automatic step();
        ram_req_t r;
        if (spurious) begin
            bus.fetch_valid = 1'b1;
            bus.fetch_data  = 32'hDEAD_BEEF;
        end else if (ram_q.size() != 0 && ram_q[0].due <= cyc) begin
            r = ram_q.pop_front();
            bus.fetch_valid = 1'b1;
            bus.fetch_data  = mem_word(r.addr);
        end else begin
            bus.fetch_valid = 1'b0;
            bus.fetch_data  = '0;
        end
        #1;
        if (reset) begin
            check_eq("reset_fetch_req", bus.fetch_req, 0);
            check_eq("reset_instr_valid", bus.instr_valid, 0);
        end else begin
            if (halt || redirect_en) check_eq("issue_gated", bus.fetch_req, 0);
            if (bus.fetch_req) begin
                check_eq("fetch_address", bus.fetch_address, exp_fetch);
                ram_q.push_back('{bus.fetch_address, cyc + lat});
                exp_fetch++;
                check_eq("credit_limit", ram_q.size() <= 2, 1);
            end
            if (bus.instr_valid && !redirect_en) begin
                check_eq("instr_pc", bus.instr_pc, exp_pc);
                check_eq("instr", bus.instr, mem_word(exp_pc));
                if (bus.instr_ready) begin
                    exp_pc++;
                    consumed++;
                end
            end
            if (redirect_en) begin
                exp_pc    = redirect_pc;
                exp_fetch = redirect_pc;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        halt            = 1'b0;
        redirect_en     = 1'b0;
        redirect_pc     = '0;
        bus.instr_ready = 1'b0;
        spurious        = 1'b0;
        ram_q.delete();
        step();
        step();
        reset = 1'b0;
        ram_q.delete();
        exp_pc    = 8'h00;
        exp_fetch = 8'h00;
        #1;
        check_eq("post_reset_instr_valid", bus.instr_valid, 0);
        check_eq("post_reset_instr", bus.instr, 0);
        check_eq("post_reset_instr_pc", bus.instr_pc, 0);
        check_eq("post_reset_protocol_err", protocol_err, 0);
    endtask

    task automatic run_until_consumed(input int n, input int limit);
        int start;
        int k;
        start = consumed;
        k = 0;
        while (consumed - start < n && k < limit) begin
            step();
            k++;
        end
        check_eq("progress_timeout", (consumed - start) >= n, 1);
    endtask

    task automatic do_redirect(input logic [7:0] target);
        redirect_en = 1'b1;
        redirect_pc = target;
        step();
        redirect_en = 1'b0;
    endtask

    initial begin
        int k;
        bus.fetch_valid = 1'b0;
        bus.fetch_data  = '0;

        // Sequential stream from reset, latency 1.
        do_reset();
        lat = 1;
        bus.instr_ready = 1'b1;
        run_until_consumed(8, 60);

        // Consumer stalls: FIFO fills, issue stops, nothing lost.
        bus.instr_ready = 1'b0;
        repeat (10) step();
        check_eq("stall_instr_valid", bus.instr_valid, 1);
        check_eq("stall_fetch_req", bus.fetch_req, 0);
        check_eq("stall_ram_idle", ram_q.size(), 0);
        bus.instr_ready = 1'b1;
        run_until_consumed(6, 60);

        // Redirect with two fetches in flight at latency 3.
        lat = 3;
        k = 0;
        while (ram_q.size() != 2 && k < 20) begin
            step();
            k++;
        end
        check_eq("two_in_flight", ram_q.size(), 2);
        do_redirect(8'h40);
        run_until_consumed(5, 80);

        // Redirect near the top of the address space: PC wraps.
        lat = 1;
        do_redirect(8'hFE);
        run_until_consumed(4, 40);

        // Halt at pc=5 for six cycles, then resume without gaps.
        do_reset();
        bus.instr_ready = 1'b1;
        k = 0;
        while (exp_fetch != 8'h05 && k < 40) begin
            step();
            k++;
        end
        check_eq("reached_pc5", exp_fetch, 8'h05);
        halt = 1'b1;
        repeat (6) step();
        halt = 1'b0;
        run_until_consumed(4, 40);
        check_eq("clean_protocol_err", protocol_err, 0);

        // Unsolicited Ram response: flagged, FIFO untouched, cleared by reset.
        halt = 1'b1;
        bus.instr_ready = 1'b0;
        repeat (6) step();
        check_eq("buffered_before_spurious", bus.instr_valid, 1);
        held_pc = bus.instr_pc;
        spurious = 1'b1;
        step();
        spurious = 1'b0;
        step();
        check_eq("protocol_err_set", protocol_err, 1);
        check_eq("spurious_head_kept", bus.instr_pc, held_pc);
        bus.instr_ready = 1'b1;
        repeat (6) step();
        check_eq("spurious_not_buffered", bus.instr_valid, 0);
        check_eq("protocol_err_sticky", protocol_err, 1);
        do_reset();

        // Randomized ready/halt/redirect traffic for each Ram latency.
        for (int l = 1; l <= 3; l++) begin
            lat = l;
            for (int i = 0; i < 300; i++) begin
                bus.instr_ready = ($urandom_range(0, 3) != 0);
                halt            = ($urandom_range(0, 9) == 0);
                redirect_en     = ($urandom_range(0, 29) == 0);
                redirect_pc     = 8'($urandom);
                step();
            end
            redirect_en     = 1'b0;
            halt            = 1'b0;
            bus.instr_ready = 1'b1;
            run_until_consumed(3, 40);
            check_eq("random_protocol_err", protocol_err, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
